// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage_if
// Purpose  : Handshake bundle for one pipe_skid_stage instance. It carries the
//            upstream valid/ready/data, the downstream valid/ready/data, the
//            flush strobe, and the status outputs (occupancy, statistics).
// Modports : master - the environment that drives the stage (upstream
//                     producer, downstream consumer, flush control).
//            slave  - the stage itself.
// Params   : DATA_W - payload width; CNT_W - statistics counter width.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if #(
  parameter int DATA_W = 71,
  parameter int CNT_W  = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  xfer_count;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, xfer_count, stall_count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, xfer_count, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Handshaked pipeline stage register with a two-entry skid buffer,
//            so that in_ready is a flop output and never combinationally
//            depends on out_ready. Carries an opaque DATA_W-bit payload in
//            strict FIFO order, with synchronous flush.
// Ports    : clk  - clock, all state updates on posedge
//            rst  - synchronous active-high reset (priority over flush)
//            bus  - pipe_skid_stage_if.slave: flush, in_valid/in_ready/
//                   in_data, out_valid/out_ready/out_data, occupancy,
//                   xfer_count, stall_count
// Config   : define PIPE_SKID_STAGE_STATS_EN to build the saturating
//            transfer/stall counters; otherwise both counters read 0 and no
//            counter flops exist.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int DATA_W = 71,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_skid_stage_if.slave      bus
);

  // State is literally {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;

  logic main_v;
  logic skid_v;
  logic in_hs;
  logic out_hs;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign main_v = state[0];
  assign skid_v = state[1];

  // in_ready comes straight from the skid flag, so it is registered.
  assign in_hs  = bus.in_valid && !skid_v;
  assign out_hs = main_v && bus.out_ready;

  // --------------------------------------------------------------------------
  // Next-state and load-enable decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_hs) begin
          state_nxt  = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_hs && out_hs) begin
          ld_main_in = 1'b1;
        end else if (in_hs) begin
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (out_hs) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_hs) begin
          state_nxt    = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and payload registers. Reset and flush have the same effect on the
  // storage; any input accepted in a flush cycle is simply dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state  <= EMPTY;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      state <= state_nxt;
      if (ld_main_in) begin
        main_d <= bus.in_data;
      end else if (ld_main_skid) begin
        main_d <= skid_d;
      end
      if (ld_skid) begin
        skid_d <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d;
  assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};

  // --------------------------------------------------------------------------
  // Statistics: saturating counters, cleared by rst only. A handshake in a
  // flush cycle still completes, so it still counts.
  // --------------------------------------------------------------------------
`ifdef PIPE_SKID_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_hs && (xfer_cnt != CNT_MAX)) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (main_v && !bus.out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.xfer_count  = xfer_cnt;
  assign bus.stall_count = stall_cnt;
`else
  assign bus.xfer_count  = {CNT_W{1'b0}};
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_stage
// Purpose  : Directed self-checking bench for pipe_skid_stage: reset, stream,
//            backpressure/skid, flush while full, reset while full, statistics
//            saturation, and a random valid/ready run against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;
  localparam int DW = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected statistics value depends on whether the counters are built.
  function automatic logic [63:0] st(input int v);
`ifdef PIPE_SKID_STAGE_STATS_EN
    return 64'(v);
`else
    return 64'(v) & 64'd0;
`endif
  endfunction

  // Advance one edge; land 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] seq;
    int            illegal;
    int            guard;

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;

    // ---------------- reset values ----------------
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_xfer", 64'(bus.xfer_count), 64'd0);
    chk("rst_stall", 64'(bus.stall_count), 64'd0);

    // ---------------- stream 1..4 ----------------
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = DW'(i);
      step();
      chk("str_out_valid", 64'(bus.out_valid), 64'd1);
      chk("str_out_data", 64'(bus.out_data), 64'(i));
      chk("str_in_ready", 64'(bus.in_ready), 64'd1);
      chk("str_occ", 64'(bus.occupancy), 64'd1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("str_drain_occ", 64'(bus.occupancy), 64'd0);
    chk("str_xfer", 64'(bus.xfer_count), st(4));

    // ---------------- backpressure skid ----------------
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'h000A;
    step();
    chk("bp_a_out", 64'(bus.out_data), 64'h0A);
    chk("bp_a_rdy", 64'(bus.in_ready), 64'd1);
    bus.in_data = 16'h000B;
    step();
    chk("bp_b_out", 64'(bus.out_data), 64'h0A);
    chk("bp_b_rdy", 64'(bus.in_ready), 64'd0);
    chk("bp_b_occ", 64'(bus.occupancy), 64'd2);
    bus.in_data = 16'h000C;
    step();
    chk("bp_c_occ", 64'(bus.occupancy), 64'd2);
    chk("bp_c_out", 64'(bus.out_data), 64'h0A);
    chk("bp_stall", 64'(bus.stall_count), st(2));
    bus.out_ready = 1'b1;
    step();
    chk("bp_rel_out", 64'(bus.out_data), 64'h0B);
    chk("bp_rel_rdy", 64'(bus.in_ready), 64'd1);
    chk("bp_rel_occ", 64'(bus.occupancy), 64'd1);
    step();
    chk("bp_c_deliver", 64'(bus.out_data), 64'h0C);
    chk("bp_c_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    step();
    chk("bp_end_occ", 64'(bus.occupancy), 64'd0);
    chk("bp_xfer", 64'(bus.xfer_count), st(7));

    // ---------------- flush while FULL ----------------
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0011;
    step();
    bus.in_data = 16'h0022;
    step();
    chk("fl_full_occ", 64'(bus.occupancy), 64'd2);
    bus.flush = 1'b1;
    bus.in_data = 16'h0033;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_out_data", 64'(bus.out_data), 64'd0);
    chk("fl_occ", 64'(bus.occupancy), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    chk("fl_stall_kept", 64'(bus.stall_count), st(4));
    chk("fl_xfer_kept", 64'(bus.xfer_count), st(7));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_leak", 64'(bus.out_valid), 64'd0);
    end

    // ---------------- reset during stall ----------------
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0044;
    step();
    bus.in_data = 16'h0055;
    step();
    chk("rs_full_occ", 64'(bus.occupancy), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rs_out_data", 64'(bus.out_data), 64'd0);
    chk("rs_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rs_occ", 64'(bus.occupancy), 64'd0);
    chk("rs_xfer", 64'(bus.xfer_count), 64'd0);
    chk("rs_stall", 64'(bus.stall_count), 64'd0);

    // ---------------- statistics saturation ----------------
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0066;
    step();
    bus.in_valid = 1'b0;
    repeat (300) step();
    chk("st_stall_sat", 64'(bus.stall_count), st(255));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("st_flush_keep", 64'(bus.stall_count), st(255));
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = DW'(16'h0100 + i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("st_xfer5", 64'(bus.xfer_count), st(5));
    chk("st_stall_hold", 64'(bus.stall_count), st(255));

    // ---------------- random valid/ready with scoreboard ----------------
    seq = 16'h1000;
    illegal = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data = seq;
      if (!bus.out_valid && !bus.in_ready) illegal++;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_dup", 64'd1, 64'd0);
        end else begin
          exp_d = q.pop_front();
          chk("rnd_data", 64'(bus.out_data), 64'(exp_d));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(seq);
        seq = seq + 16'd1;
      end
      step();
    end
    // Drain with a bounded wait.
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      if (bus.out_valid) begin
        exp_d = q.pop_front();
        chk("rnd_drain", 64'(bus.out_data), 64'(exp_d));
      end
      step();
      guard++;
    end
    chk("rnd_left", 64'(q.size()), 64'd0);
    chk("rnd_empty", 64'(bus.out_valid), 64'd0);
    chk("rnd_state10", 64'(illegal), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
